// File: rtl/vlsu_pkg.sv
// Shared VLSU types: the load meta-info bundle and the dispatch FSM encoding.
package vlsu_pkg;

  localparam int unsigned NR_VINSN = 8;
  localparam int unsigned ID_W     = $clog2(NR_VINSN);

  typedef struct packed {
    logic [ID_W-1:0] req_id;
    logic [1:0]      mode;
    logic [1:0]      sew;
    logic [4:0]      vd;
    logic [7:0]      vstart;
    logic            vm;
    logic [7:0]      cmt_cnt;
  } meta_glb_t;

  typedef enum logic {
    DS_IDLE,
    DS_FORK
  } dispatch_state_e;

endpackage

// File: rtl/vlsu_meta_fork.sv
// N-way stream fork: each output keeps its valid until its own handshake.
// Outputs with en low are treated as already delivered.
module vlsu_meta_fork #(
  parameter int unsigned N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         active,
  input  logic [N-1:0] en,
  input  logic [N-1:0] ready,
  output logic [N-1:0] valid,
  output logic         last
);

  logic [N-1:0] sent;
  logic [N-1:0] fire;

  assign valid = {N{active}} & en & ~sent;
  assign fire  = valid & ready;
  assign last  = active && (&(sent | ~en | fire));

  // A new load restarts delivery for every consumer, even when it lands on the last handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      sent <= '0;
    end else if (load) begin
      sent <= '0;
    end else begin
      sent <= sent | fire;
    end
  end

endmodule

// File: rtl/vlsu_load_dispatch_ctrl.sv
// VLSU load front-end: accepts one load micro-op, forks its meta info to the
// shuffle, sequential-load and mask units, and tracks in-flight reqIds until done.
module vlsu_load_dispatch_ctrl
  import vlsu_pkg::*;
#(
  parameter int unsigned NrVInsn     = NR_VINSN,
  parameter int unsigned MaxInflight = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  meta_glb_t                     req_i,
  output logic                          shf_meta_valid_o,
  input  logic                          shf_meta_ready_i,
  output logic                          seq_meta_valid_o,
  input  logic                          seq_meta_ready_i,
  output logic                          mask_meta_valid_o,
  input  logic                          mask_meta_ready_i,
  output meta_glb_t                     meta_o,
  input  logic [NrVInsn-1:0]            vinsn_done_i,
  output logic                          done_valid_o,
  output logic [$clog2(NrVInsn)-1:0]    done_id_o,
  output logic [NrVInsn-1:0]            busy_o,
  output logic                          idle_o
);

  localparam int unsigned IdW  = $clog2(NrVInsn);
  localparam int unsigned CntW = $clog2(MaxInflight + 1);

  dispatch_state_e   state;
  logic [CntW-1:0]   inflight;
  logic [NrVInsn-1:0] busy;
  logic              admissible;
  logic              fork_last;
  logic              accept;
  logic              done_hit;
  logic [IdW-1:0]    done_idx;
  logic [2:0]        fork_en;
  logic [2:0]        fork_ready;
  logic [2:0]        fork_valid;

  assign busy_o      = busy;
  assign admissible  = !busy[req_i.req_id] && (inflight < CntW'(MaxInflight));
  assign req_ready_o = admissible && ((state == DS_IDLE) || fork_last);
  assign accept      = req_valid_i && req_ready_o;
  assign idle_o      = (state == DS_IDLE) && (inflight == '0);

  // Consumer order is {mask, seq, shf}; the mask unit only sees masked loads.
  assign fork_en    = {!meta_o.vm, 2'b11};
  assign fork_ready = {mask_meta_ready_i, seq_meta_ready_i, shf_meta_ready_i};
  assign {mask_meta_valid_o, seq_meta_valid_o, shf_meta_valid_o} = fork_valid;

  vlsu_meta_fork #(
    .N (3)
  ) u_fork (
    .clk    (clk_i),
    .rst    (rst_i),
    .load   (accept),
    .active (state == DS_FORK),
    .en     (fork_en),
    .ready  (fork_ready),
    .valid  (fork_valid),
    .last   (fork_last)
  );

  always_comb begin
    done_idx = '0;
    for (int i = 0; i < NrVInsn; i++) begin
      if (vinsn_done_i[i]) done_idx = IdW'(i);
    end
  end

  // Completions for ids that are not in flight are dropped here.
  assign done_hit = |(vinsn_done_i & busy);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= DS_IDLE;
      meta_o <= '0;
    end else if (accept) begin
      state  <= DS_FORK;
      meta_o <= req_i;
    end else if (fork_last) begin
      state  <= DS_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy         <= '0;
      inflight     <= '0;
      done_valid_o <= 1'b0;
      done_id_o    <= '0;
    end else begin
      busy <= (busy & ~vinsn_done_i) | (accept ? (NrVInsn'(1) << req_i.req_id) : '0);
      if (accept && !done_hit) begin
        inflight <= inflight + CntW'(1);
      end else if (!accept && done_hit) begin
        inflight <= inflight - CntW'(1);
      end
      done_valid_o <= done_hit;
      if (done_hit) done_id_o <= done_idx;
    end
  end

  a_done_onehot : assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(vinsn_done_i));
  a_done_busy : assert property (@(posedge clk_i) disable iff (rst_i)
    (vinsn_done_i == '0) || ((vinsn_done_i & busy) != '0));
  a_inflight_max : assert property (@(posedge clk_i) disable iff (rst_i)
    inflight <= CntW'(MaxInflight));
  a_inflight_underflow : assert property (@(posedge clk_i) disable iff (rst_i)
    done_hit |-> (inflight != '0));

endmodule

// File: tb/tb_vlsu_load_dispatch_ctrl.sv
// Self-checking bench for vlsu_load_dispatch_ctrl: directed scenarios plus a
// randomized run against a transaction-level model of the dispatcher.
module tb_vlsu_load_dispatch_ctrl;
  import vlsu_pkg::*;

  localparam int NR  = 8;
  localparam int MAX = 4;

  logic            clk_i;
  logic            rst_i;
  logic            req_valid_i;
  logic            req_ready_o;
  meta_glb_t       req_i;
  logic            shf_meta_valid_o;
  logic            shf_meta_ready_i;
  logic            seq_meta_valid_o;
  logic            seq_meta_ready_i;
  logic            mask_meta_valid_o;
  logic            mask_meta_ready_i;
  meta_glb_t       meta_o;
  logic [NR-1:0]   vinsn_done_i;
  logic            done_valid_o;
  logic [ID_W-1:0] done_id_o;
  logic [NR-1:0]   busy_o;
  logic            idle_o;
  logic [2:0]      valids;

  int n_checks = 0;
  int n_fail   = 0;

  assign valids = {mask_meta_valid_o, seq_meta_valid_o, shf_meta_valid_o};

  vlsu_load_dispatch_ctrl #(
    .NrVInsn     (NR),
    .MaxInflight (MAX)
  ) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .req_valid_i       (req_valid_i),
    .req_ready_o       (req_ready_o),
    .req_i             (req_i),
    .shf_meta_valid_o  (shf_meta_valid_o),
    .shf_meta_ready_i  (shf_meta_ready_i),
    .seq_meta_valid_o  (seq_meta_valid_o),
    .seq_meta_ready_i  (seq_meta_ready_i),
    .mask_meta_valid_o (mask_meta_valid_o),
    .mask_meta_ready_i (mask_meta_ready_i),
    .meta_o            (meta_o),
    .vinsn_done_i      (vinsn_done_i),
    .done_valid_o      (done_valid_o),
    .done_id_o         (done_id_o),
    .busy_o            (busy_o),
    .idle_o            (idle_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_readies(input bit shf, input bit seq, input bit mask);
    shf_meta_ready_i  = shf;
    seq_meta_ready_i  = seq;
    mask_meta_ready_i = mask;
  endtask

  function automatic meta_glb_t make_req(input int id, input bit vm);
    meta_glb_t   m;
    logic [31:0] r;
    r = $urandom();
    m = r[$bits(meta_glb_t)-1:0];
    m.req_id = ID_W'(id);
    m.vm = vm;
    return m;
  endfunction

  task automatic do_reset();
    rst_i        = 1'b1;
    req_valid_i  = 1'b0;
    req_i        = '0;
    vinsn_done_i = '0;
    set_readies(0, 0, 0);
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i        = 1'b1;
    req_valid_i  = 1'b1;
    req_i        = make_req(5, 0);
    vinsn_done_i = '0;
    set_readies(1, 1, 1);
    tick();
    tick();
    req_valid_i = 1'b0;
    req_i       = '0;
    @(negedge clk_i);
    n_checks++; if (valids !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_valids: got %b expected 000", valids); end
    n_checks++; if (busy_o !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_busy: got %h expected 00", busy_o); end
    n_checks++; if (done_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done_valid: got %b expected 0", done_valid_o); end
    n_checks++; if (done_id_o !== '0) begin n_fail++; $display("[TB] FAIL reset_done_id: got %0d expected 0", done_id_o); end
    n_checks++; if (meta_o !== '0) begin n_fail++; $display("[TB] FAIL reset_meta: got %h expected 0", meta_o); end
    n_checks++; if (idle_o !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_idle: got %b expected 1", idle_o); end
    n_checks++; if (req_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %b expected 1", req_ready_o); end
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_unmasked();
    meta_glb_t m;
    do_reset();
    set_readies(1, 1, 1);
    m = make_req(2, 1);
    req_i = m;
    req_valid_i = 1'b1;
    @(negedge clk_i);
    n_checks++; if (req_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL unmasked_accept_ready: got %b expected 1", req_ready_o); end
    n_checks++; if (valids !== 3'b000) begin n_fail++; $display("[TB] FAIL unmasked_accept_valids: got %b expected 000", valids); end
    tick();
    req_valid_i = 1'b0;
    @(negedge clk_i);
    n_checks++; if (valids !== 3'b011) begin n_fail++; $display("[TB] FAIL unmasked_fork_valids: got %b expected 011", valids); end
    n_checks++; if (busy_o !== 8'h04) begin n_fail++; $display("[TB] FAIL unmasked_busy: got %h expected 04", busy_o); end
    n_checks++; if (idle_o !== 1'b0) begin n_fail++; $display("[TB] FAIL unmasked_idle_busy: got %b expected 0", idle_o); end
    n_checks++; if (meta_o !== m) begin n_fail++; $display("[TB] FAIL unmasked_meta: got %h expected %h", meta_o, m); end
    tick();
    @(negedge clk_i);
    n_checks++; if (valids !== 3'b000) begin n_fail++; $display("[TB] FAIL unmasked_valids_drop: got %b expected 000", valids); end
    n_checks++; if (idle_o !== 1'b0) begin n_fail++; $display("[TB] FAIL unmasked_idle_inflight: got %b expected 0", idle_o); end
    tick();
    vinsn_done_i = 8'h04;
    tick();
    vinsn_done_i = '0;
    @(negedge clk_i);
    n_checks++; if (done_valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL unmasked_done_valid: got %b expected 1", done_valid_o); end
    n_checks++; if (done_id_o !== 3'd2) begin n_fail++; $display("[TB] FAIL unmasked_done_id: got %0d expected 2", done_id_o); end
    n_checks++; if (busy_o !== 8'h00) begin n_fail++; $display("[TB] FAIL unmasked_busy_clear: got %h expected 00", busy_o); end
    n_checks++; if (idle_o !== 1'b1) begin n_fail++; $display("[TB] FAIL unmasked_idle_back: got %b expected 1", idle_o); end
    tick();
    @(negedge clk_i);
    n_checks++; if (done_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL unmasked_done_pulse: got %b expected 0", done_valid_o); end
  endtask

  task automatic test_masked();
    meta_glb_t m;
    logic [2:0] exp_v;
    do_reset();
    set_readies(0, 0, 0);
    m = make_req(5, 0);
    req_i = m;
    req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    req_i = make_req(6, 1);
    for (int c = 1; c <= 6; c++) begin
      set_readies(c == 1, c == 3, c == 5);
      exp_v = {c <= 5, c <= 3, c <= 1};
      @(negedge clk_i);
      n_checks++; if (valids !== exp_v) begin n_fail++; $display("[TB] FAIL masked_valids_c%0d: got %b expected %b", c, valids, exp_v); end
      n_checks++; if (req_ready_o !== (c >= 5)) begin n_fail++; $display("[TB] FAIL masked_ready_c%0d: got %b expected %b", c, req_ready_o, c >= 5); end
      n_checks++; if (meta_o !== m) begin n_fail++; $display("[TB] FAIL masked_meta_c%0d: got %h expected %h", c, meta_o, m); end
      tick();
    end
    set_readies(0, 0, 0);
  endtask

  task automatic test_inflight_limit();
    do_reset();
    set_readies(1, 1, 1);
    req_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_i = make_req(i, 1);
      @(negedge clk_i);
      n_checks++; if (req_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL limit_b2b_ready_%0d: got %b expected 1", i, req_ready_o); end
      tick();
    end
    req_i = make_req(4, 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      n_checks++; if (req_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL limit_stall_%0d: got %b expected 0", c, req_ready_o); end
      tick();
    end
    @(negedge clk_i);
    n_checks++; if (busy_o !== 8'h0F) begin n_fail++; $display("[TB] FAIL limit_busy_full: got %h expected 0f", busy_o); end
    tick();
    vinsn_done_i = 8'h02;
    @(negedge clk_i);
    n_checks++; if (req_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL limit_same_cycle_done: got %b expected 0", req_ready_o); end
    tick();
    vinsn_done_i = '0;
    @(negedge clk_i);
    n_checks++; if (req_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL limit_reopen: got %b expected 1", req_ready_o); end
    n_checks++; if (done_valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL limit_done_valid: got %b expected 1", done_valid_o); end
    n_checks++; if (done_id_o !== 3'd1) begin n_fail++; $display("[TB] FAIL limit_done_id: got %0d expected 1", done_id_o); end
    n_checks++; if (busy_o !== 8'h0D) begin n_fail++; $display("[TB] FAIL limit_busy_after_done: got %h expected 0d", busy_o); end
    tick();
    req_valid_i = 1'b0;
    @(negedge clk_i);
    n_checks++; if (busy_o !== 8'h1D) begin n_fail++; $display("[TB] FAIL limit_fifth_busy: got %h expected 1d", busy_o); end
    n_checks++; if (shf_meta_valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL limit_fifth_valid: got %b expected 1", shf_meta_valid_o); end
    tick();
  endtask

  task automatic test_busy_collision();
    do_reset();
    set_readies(1, 1, 1);
    req_i = make_req(3, 1);
    req_valid_i = 1'b1;
    tick();
    req_i = make_req(3, 0);
    @(negedge clk_i);
    n_checks++; if (req_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL collide_stall: got %b expected 0", req_ready_o); end
    n_checks++; if (busy_o !== 8'h08) begin n_fail++; $display("[TB] FAIL collide_busy: got %h expected 08", busy_o); end
    tick();
    vinsn_done_i = 8'h08;
    @(negedge clk_i);
    n_checks++; if (req_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL collide_same_cycle: got %b expected 0", req_ready_o); end
    tick();
    vinsn_done_i = '0;
    @(negedge clk_i);
    n_checks++; if (req_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL collide_reopen: got %b expected 1", req_ready_o); end
    tick();
    req_valid_i = 1'b0;
    @(negedge clk_i);
    n_checks++; if (busy_o !== 8'h08) begin n_fail++; $display("[TB] FAIL collide_rebusy: got %h expected 08", busy_o); end
    n_checks++; if (valids !== 3'b111) begin n_fail++; $display("[TB] FAIL collide_valids: got %b expected 111", valids); end
    tick();
  endtask

  task automatic test_reset_mid_fork();
    do_reset();
    set_readies(1, 0, 0);
    req_i = make_req(1, 1);
    req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    @(negedge clk_i);
    n_checks++; if (valids !== 3'b011) begin n_fail++; $display("[TB] FAIL midrst_fork_valids: got %b expected 011", valids); end
    tick();
    @(negedge clk_i);
    n_checks++; if (valids !== 3'b010) begin n_fail++; $display("[TB] FAIL midrst_seq_pending: got %b expected 010", valids); end
    rst_i = 1'b1;
    vinsn_done_i = 8'h02;
    tick();
    rst_i = 1'b0;
    vinsn_done_i = '0;
    @(negedge clk_i);
    n_checks++; if (valids !== 3'b000) begin n_fail++; $display("[TB] FAIL midrst_valids: got %b expected 000", valids); end
    n_checks++; if (busy_o !== 8'h00) begin n_fail++; $display("[TB] FAIL midrst_busy: got %h expected 00", busy_o); end
    n_checks++; if (idle_o !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_idle: got %b expected 1", idle_o); end
    n_checks++; if (done_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_no_done: got %b expected 0", done_valid_o); end
    tick();
    @(negedge clk_i);
    n_checks++; if (done_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_no_done_late: got %b expected 0", done_valid_o); end
    set_readies(0, 0, 0);
  endtask

  // Model: one optional in-progress micro-op with a set of consumers still owed
  // the meta, plus the set of reqIds in flight; inflight is the size of that set.
  task automatic test_random();
    bit              m_have;
    bit [2:0]        m_owed;
    meta_glb_t       m_meta;
    bit [NR-1:0]     m_busy;
    bit              m_dv;
    logic [ID_W-1:0] m_did;
    int              cnt;
    int              k;
    bit [2:0]        exp_v;
    bit [2:0]        hs;
    bit              finishing;
    bit              exp_rdy;
    bit              exp_idle;
    logic [31:0]     r;
    do_reset();
    m_have = 0; m_owed = '0; m_meta = '0; m_busy = '0; m_dv = 0; m_did = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      req_valid_i = ($urandom_range(0, 3) != 0);
      r = $urandom();
      req_i = r[$bits(meta_glb_t)-1:0];
      set_readies($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      k = $urandom_range(0, NR - 1);
      vinsn_done_i = '0;
      if (m_busy[k] && ($urandom_range(0, 2) == 0)) vinsn_done_i[k] = 1'b1;
      @(negedge clk_i);
      cnt = 0;
      for (int i = 0; i < NR; i++) cnt += int'(m_busy[i]);
      exp_v     = m_have ? m_owed : 3'b000;
      hs        = exp_v & {mask_meta_ready_i, seq_meta_ready_i, shf_meta_ready_i};
      finishing = m_have && ((m_owed & ~hs) == 3'b000);
      exp_rdy   = !m_busy[req_i.req_id] && (cnt < MAX) && (!m_have || finishing);
      exp_idle  = !m_have && (cnt == 0);
      n_checks++; if (req_ready_o !== exp_rdy) begin n_fail++; $display("[TB] FAIL rand_ready cyc%0d: got %b expected %b", cyc, req_ready_o, exp_rdy); end
      n_checks++; if (valids !== exp_v) begin n_fail++; $display("[TB] FAIL rand_valids cyc%0d: got %b expected %b", cyc, valids, exp_v); end
      n_checks++; if (busy_o !== m_busy) begin n_fail++; $display("[TB] FAIL rand_busy cyc%0d: got %h expected %h", cyc, busy_o, m_busy); end
      n_checks++; if (idle_o !== exp_idle) begin n_fail++; $display("[TB] FAIL rand_idle cyc%0d: got %b expected %b", cyc, idle_o, exp_idle); end
      n_checks++; if (meta_o !== m_meta) begin n_fail++; $display("[TB] FAIL rand_meta cyc%0d: got %h expected %h", cyc, meta_o, m_meta); end
      n_checks++; if (done_valid_o !== m_dv) begin n_fail++; $display("[TB] FAIL rand_done_valid cyc%0d: got %b expected %b", cyc, done_valid_o, m_dv); end
      if (m_dv) begin
        n_checks++; if (done_id_o !== m_did) begin n_fail++; $display("[TB] FAIL rand_done_id cyc%0d: got %0d expected %0d", cyc, done_id_o, m_did); end
      end
      m_dv = (vinsn_done_i != '0);
      if (m_dv) begin
        m_busy[k] = 1'b0;
        m_did = ID_W'(k);
      end
      if (req_valid_i && exp_rdy) begin
        m_have = 1;
        m_meta = req_i;
        m_owed = {!req_i.vm, 2'b11};
        m_busy[req_i.req_id] = 1'b1;
      end else if (finishing) begin
        m_have = 0;
      end else begin
        m_owed = m_owed & ~hs;
      end
      tick();
    end
    req_valid_i = 1'b0;
    vinsn_done_i = '0;
    set_readies(0, 0, 0);
  endtask

  initial begin
    rst_i = 1'b1;
    req_valid_i = 1'b0;
    req_i = '0;
    vinsn_done_i = '0;
    set_readies(0, 0, 0);
    test_reset();
    test_unmasked();
    test_masked();
    test_inflight_limit();
    test_busy_collision();
    test_reset_mid_fork();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
